// File: rtl/div_issue_ctrl.sv
// rtl/div_issue_ctrl.sv - EX-stage issue, stall and result control for the multi-cycle divider
// Optional DIV_RESULT_CACHE_EN: last-result cache that bypasses the divider on an operand match.
module div_issue_ctrl #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [2:0]      ex_funct3,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic            flush,
    output logic            ex_stall,
    output logic [XLEN-1:0] result,
    output logic            result_valid,
    output logic            div_start,
    output logic [2:0]      div_op,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] divisor,
    input  logic [XLEN-1:0] quotient,
    input  logic [XLEN-1:0] remainder,
    input  logic            div_done
);
    typedef enum logic [1:0] {IDLE, WAIT, DONE, DRAIN} state_t;

    state_t          state;
    logic            req;
    logic            cache_hit;
    logic [XLEN-1:0] cache_result;

    assign req = ex_valid & ex_funct3[2] & ~flush;

`ifdef DIV_RESULT_CACHE_EN
    logic            c_valid;
    logic            c_unsigned;
    logic [XLEN-1:0] c_rs1;
    logic [XLEN-1:0] c_rs2;
    logic [XLEN-1:0] c_quot;
    logic [XLEN-1:0] c_rem;

    assign cache_hit = c_valid & (rs1_data == c_rs1) & (rs2_data == c_rs2)
                     & (ex_funct3[0] == c_unsigned);
    assign cache_result = ex_funct3[1] ? c_rem : c_quot;

    // Only a completed, unflushed division may populate the cache.
    always_ff @(posedge clk) begin
        if (rst) begin
            c_valid    <= 1'b0;
            c_unsigned <= 1'b0;
            c_rs1      <= '0;
            c_rs2      <= '0;
            c_quot     <= '0;
            c_rem      <= '0;
        end else if (state == WAIT && div_done && !flush) begin
            c_valid    <= 1'b1;
            c_unsigned <= div_op[0];
            c_rs1      <= dividend;
            c_rs2      <= divisor;
            c_quot     <= quotient;
            c_rem      <= remainder;
        end
    end
`else
    assign cache_hit    = 1'b0;
    assign cache_result = '0;
`endif

    always_comb begin
        ex_stall = 1'b0;
        case (state)
            IDLE:    ex_stall = req & ~cache_hit;
            WAIT:    ex_stall = 1'b1;
            DRAIN:   ex_stall = req;
            default: ex_stall = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            div_start    <= 1'b0;
            result_valid <= 1'b0;
            result       <= '0;
            dividend     <= '0;
            divisor      <= '0;
            div_op       <= '0;
        end else begin
            div_start    <= 1'b0;
            result_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        if (cache_hit) begin
                            result       <= cache_result;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end else begin
                            dividend  <= rs1_data;
                            divisor   <= rs2_data;
                            div_op    <= ex_funct3;
                            div_start <= 1'b1;
                            state     <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (div_done) begin
                        if (flush) begin
                            state <= IDLE;
                        end else begin
                            result       <= div_op[1] ? remainder : quotient;
                            result_valid <= 1'b1;
                            state        <= DONE;
                        end
                    end else if (flush) begin
                        state <= DRAIN;
                    end
                end
                DONE: state <= IDLE;
                // The divider is still working on the killed request; wait it out before relaunching.
                DRAIN: begin
                    if (div_done) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_div_issue_ctrl.sv
// tb/tb_div_issue_ctrl.sv - randomized scoreboard bench for div_issue_ctrl with a behavioural divider
module tb_div_issue_ctrl;
    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [2:0]  ex_funct3;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        flush;
    logic        ex_stall;
    logic [31:0] result;
    logic        result_valid;
    logic        div_start;
    logic [2:0]  div_op;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [31:0] quotient;
    logic [31:0] remainder;
    logic        div_done;

    int tests = 0;
    int fails = 0;
    int starts_total = 0;
    int exp_starts = 0;
    int force_lat = 0;
    logic [31:0] sb_q[$];

`ifdef DIV_RESULT_CACHE_EN
    bit          c_valid = 0;
    bit          c_s;
    logic [31:0] c_a;
    logic [31:0] c_b;
`endif

    div_issue_ctrl #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_funct3(ex_funct3),
        .rs1_data(rs1_data), .rs2_data(rs2_data), .flush(flush),
        .ex_stall(ex_stall), .result(result), .result_valid(result_valid),
        .div_start(div_start), .div_op(div_op), .dividend(dividend), .divisor(divisor),
        .quotient(quotient), .remainder(remainder), .div_done(div_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RV32M semantics: {quotient, remainder}; wide signed math absorbs the overflow case.
    function automatic logic [63:0] ref_qr(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [31:0] q, r;
        if (b == 32'd0) begin
            q = 32'hFFFFFFFF;
            r = a;
        end else if (!f3[0]) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            q = 32'(sa / sb);
            r = 32'(sa % sb);
        end else begin
            q = a / b;
            r = a % b;
        end
        return {q, r};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    // Behavioural divider with random latency.
    bit          d_busy = 0, d_fire, d_was_busy;
    int          d_cnt = 0;
    logic [31:0] d_a, d_b;
    logic [2:0]  d_op;
    logic [63:0] d_qr;
    initial begin
        div_done = 0; quotient = 0; remainder = 0;
        forever begin
            @(negedge clk);
            d_fire = 0;
            d_was_busy = d_busy;
            if (rst) begin
                d_busy = 0;
            end else begin
                if (d_busy) begin
                    check("hold_dividend", dividend, d_a);
                    check("hold_divisor", divisor, d_b);
                    check("hold_op", 32'(div_op), 32'(d_op));
                    d_cnt--;
                    if (d_cnt == 0) begin
                        d_fire = 1;
                        d_busy = 0;
                    end
                end
                if (div_start) begin
                    starts_total++;
                    check("start_while_busy", 32'(d_was_busy), 32'd0);
                    d_a = dividend; d_b = divisor; d_op = div_op;
                    d_cnt = (force_lat != 0) ? force_lat : $urandom_range(1, 5);
                    d_busy = 1;
                end
            end
            @(posedge clk); #2;
            div_done = d_fire;
            if (d_fire) begin
                d_qr = ref_qr(d_op, d_a, d_b);
                quotient = d_qr[63:32];
                remainder = d_qr[31:0];
            end else begin
                quotient = $urandom;
                remainder = $urandom;
            end
        end
    end

    // Monitor: every presented result must match the head of the scoreboard.
    bit          m_prev_rv = 0, m_prev_done = 0;
    logic [31:0] m_exp;
    initial begin
        forever begin
            @(negedge clk);
            if (result_valid === 1'b1) begin
                check("rv_single_cycle", 32'(m_prev_rv), 32'd0);
                check("done_no_stall", 32'(ex_stall), 32'd0);
`ifndef DIV_RESULT_CACHE_EN
                check("done_latency", 32'(m_prev_done), 32'd1);
`endif
                if (sb_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_result: got 0x%08h expected none", result);
                end else begin
                    m_exp = sb_q.pop_front();
                    check("result", result, m_exp);
                end
            end
            m_prev_rv = (result_valid === 1'b1);
            m_prev_done = (div_done === 1'b1);
        end
    end

    task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input bit toggle);
        bit hit, gap;
        int waitc;
        hit = 0;
`ifdef DIV_RESULT_CACHE_EN
        hit = c_valid && (c_a == a) && (c_b == b) && (c_s == f3[0]);
`endif
        if (!hit) exp_starts++;
        sb_q.push_back(exp);
        ex_valid = 1; ex_funct3 = f3; rs1_data = a; rs2_data = b;
        #1 check("issue_stall", 32'(ex_stall), 32'(!hit));
        gap = 0;
        waitc = 0;
        do begin
            @(posedge clk); #2;
            waitc++;
            if (!result_valid) begin
                if (!ex_stall) gap = 1;
                if (toggle) begin
                    rs1_data = $urandom;
                    rs2_data = $urandom;
                end
            end
        end while (!result_valid && waitc < 100);
        if (waitc >= 100) begin
            tests++;
            fails++;
            $display("FAIL result_timeout: got no result_valid expected one within 100 cycles");
            finish_run();
        end
        check("stall_until_done", 32'(gap), 32'd0);
        @(posedge clk); #2;
        ex_valid = 0;
        check("start_count", 32'(starts_total), 32'(exp_starts));
`ifdef DIV_RESULT_CACHE_EN
        if (!hit) begin
            c_valid = 1; c_a = a; c_b = b; c_s = f3[0];
        end
`endif
    endtask

    logic [2:0]  f3;
    logic [31:0] a, b;
    logic [63:0] qr;
    initial begin
        rst = 1; ex_valid = 0; ex_funct3 = 0; rs1_data = 0; rs2_data = 0; flush = 0;
        repeat (3) begin @(posedge clk); #2; end
        check("rst_stall", 32'(ex_stall), 32'd0);
        check("rst_result_valid", 32'(result_valid), 32'd0);
        check("rst_div_start", 32'(div_start), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_dividend", dividend, 32'd0);
        rst = 0;
        @(posedge clk); #2;

        run_op(3'b100, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 1);
        run_op(3'b110, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 1);
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 1);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 1);
        run_op(3'b100, 32'd100, 32'd7, 32'd14, 1);
        run_op(3'b110, 32'd100, 32'd7, 32'd2, 0);
        run_op(3'b111, 32'd100, 32'd7, 32'd2, 0);

        // Flush three cycles into a long division while the next DIVU waits in EX.
        force_lat = 8;
        exp_starts++;
        ex_valid = 1; ex_funct3 = 3'b101; rs1_data = 32'd1000; rs2_data = 32'd3;
        repeat (3) begin @(posedge clk); #2; end
        flush = 1; rs1_data = 32'd50; rs2_data = 32'd5;
        @(posedge clk); #2;
        flush = 0; force_lat = 0;
        run_op(3'b101, 32'd50, 32'd5, 32'd10, 0);

        // Reset in the middle of a division.
        force_lat = 6;
        exp_starts++;
        ex_valid = 1; ex_funct3 = 3'b100; rs1_data = 32'd77; rs2_data = 32'd5;
        repeat (2) begin @(posedge clk); #2; end
        rst = 1; ex_valid = 0;
        @(posedge clk); #2;
        check("wait_rst_stall", 32'(ex_stall), 32'd0);
        check("wait_rst_result_valid", 32'(result_valid), 32'd0);
        check("wait_rst_div_start", 32'(div_start), 32'd0);
        check("wait_rst_result", result, 32'd0);
        check("wait_rst_divisor", divisor, 32'd0);
        check("wait_rst_div_op", 32'(div_op), 32'd0);
        rst = 0; force_lat = 0;
`ifdef DIV_RESULT_CACHE_EN
        c_valid = 0;
`endif
        @(posedge clk); #2;
        run_op(3'b101, 32'd100, 32'd7, 32'd14, 1);

        for (int i = 0; i < 40; i++) begin
            f3 = 3'(4 + $urandom_range(0, 3));
            case ($urandom_range(0, 4))
                0: begin a = $urandom; b = 32'd0; end
                1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
                2: begin a = $urandom_range(0, 1000); b = $urandom_range(1, 20); end
                default: begin a = $urandom; b = $urandom; end
            endcase
            qr = ref_qr(f3, a, b);
            run_op(f3, a, b, f3[1] ? qr[31:0] : qr[63:32], 1);
            // Gap cycles may carry non-divide M ops, which must not launch anything.
            repeat ($urandom_range(0, 2)) begin
                ex_valid = 1'($urandom_range(0, 1));
                ex_funct3 = 3'($urandom_range(0, 3));
                @(posedge clk); #2;
            end
            ex_valid = 0;
        end

        repeat (10) begin @(posedge clk); #2; end
        check("final_start_count", 32'(starts_total), 32'(exp_starts));
        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        finish_run();
    end

    initial begin
        #200000;
        tests++;
        fails++;
        $display("FAIL watchdog: got simulation still running expected completion");
        finish_run();
    end
endmodule
